// File: rtl/irq_arbiter.sv
// irq_arbiter: edge-detected, enable-masked interrupt arbiter with a one-hot grant held until eoi.
// Optional `IRQ_ROUND_ROBIN_EN replaces fixed lowest-index priority with a rotating pointer.
module irq_arbiter #(
  parameter int unsigned NUM_IRQ = 32
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [NUM_IRQ-1:0] irq_src,
  output logic [31:0]        irq,
  input  logic               eoi,
  input  logic               reg_we,
  input  logic               reg_re,
  input  logic [3:0]         reg_addr,
  input  logic [31:0]        reg_wdata,
  output logic [31:0]        reg_rdata
);
  localparam int unsigned ID_W  = 5;
  localparam int unsigned IDX_W = ID_W + 1;
  localparam logic [1:0] A_PENDING = 2'd0;
  localparam logic [1:0] A_ENABLE  = 2'd1;
  localparam logic [1:0] A_ACTIVE  = 2'd2;
  localparam logic [1:0] A_SWTRIG  = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_GAP} state_t;

  state_t             state_q, state_d;
  logic [NUM_IRQ-1:0] pending_q, pending_d, enable_q, irq_src_q;
  logic [NUM_IRQ-1:0] set_vec, w1c_vec, clr_vec, req;
  logic [31:0]        req32, irq_d, rdata_d;
  logic [ID_W-1:0]    win_id, grant_id_q, grant_id_d;
  logic               win_vld, grant;
  logic [1:0]         wsel;
  logic               unused_addr_lsb;

  assign wsel            = reg_addr[3:2];
  assign unused_addr_lsb = ^reg_addr[1:0];
  assign req             = pending_q & enable_q;
  assign req32           = 32'(req);

`ifdef IRQ_ROUND_ROBIN_EN
  logic [ID_W-1:0]  rr_ptr_q;
  logic [IDX_W-1:0] rr_idx;

  // First requesting source at or above the pointer, wrapping at NUM_IRQ.
  always_comb begin
    win_id  = '0;
    win_vld = 1'b0;
    rr_idx  = '0;
    for (int i = 0; i < int'(NUM_IRQ); i++) begin
      rr_idx = {1'b0, rr_ptr_q} + IDX_W'(i);
      if (rr_idx >= IDX_W'(NUM_IRQ)) rr_idx = rr_idx - IDX_W'(NUM_IRQ);
      if (!win_vld && req32[rr_idx[ID_W-1:0]]) begin
        win_vld = 1'b1;
        win_id  = rr_idx[ID_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rr_ptr_q <= '0;
    end else if (grant) begin
      rr_ptr_q <= (win_id == ID_W'(NUM_IRQ - 1)) ? '0 : ID_W'(win_id + ID_W'(1));
    end
  end
`else
  // Fixed priority: descending scan so the lowest requesting index is the last write.
  always_comb begin
    win_id  = '0;
    win_vld = 1'b0;
    for (int i = int'(NUM_IRQ) - 1; i >= 0; i--) begin
      if (req32[ID_W'(i)]) begin
        win_vld = 1'b1;
        win_id  = ID_W'(i);
      end
    end
  end
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (win_vld) state_d = S_ACTIVE;
      S_ACTIVE: if (eoi)     state_d = S_GAP;
      S_GAP:                 state_d = S_IDLE;
      default:               state_d = S_IDLE;
    endcase
  end

  // Grant / release decisions; the grant vector itself is registered below.
  always_comb begin
    grant      = 1'b0;
    irq_d      = irq;
    grant_id_d = grant_id_q;
    case (state_q)
      S_IDLE: begin
        if (win_vld) begin
          grant      = 1'b1;
          irq_d      = 32'(1) << win_id;
          grant_id_d = win_id;
        end
      end
      S_ACTIVE: begin
        if (eoi) begin
          irq_d      = '0;
          grant_id_d = '0;
        end
      end
      default: begin
        irq_d      = '0;
        grant_id_d = '0;
      end
    endcase
  end

  // Sets (edge or SWTRIG) win over both W1C and the grant clear.
  always_comb begin
    w1c_vec   = (reg_we && wsel == A_PENDING) ? reg_wdata[NUM_IRQ-1:0] : '0;
    set_vec   = (irq_src & ~irq_src_q)
              | ((reg_we && wsel == A_SWTRIG) ? reg_wdata[NUM_IRQ-1:0] : '0);
    clr_vec   = grant ? irq_d[NUM_IRQ-1:0] : '0;
    pending_d = (pending_q & ~w1c_vec & ~clr_vec) | set_vec;
  end

  always_comb begin
    rdata_d = '0;
    case (wsel)
      A_PENDING: rdata_d = 32'(pending_q);
      A_ENABLE:  rdata_d = 32'(enable_q);
      A_ACTIVE:  rdata_d = {state_q == S_ACTIVE, 26'd0, grant_id_q};
      default:   rdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pending_q  <= '0;
      enable_q   <= '0;
      irq_src_q  <= '0;
      irq        <= '0;
      grant_id_q <= '0;
      reg_rdata  <= '0;
    end else begin
      pending_q  <= pending_d;
      irq_src_q  <= irq_src;
      irq        <= irq_d;
      grant_id_q <= grant_id_d;
      if (reg_we && wsel == A_ENABLE) enable_q <= reg_wdata[NUM_IRQ-1:0];
      if (reg_re) reg_rdata <= rdata_d;
    end
  end

endmodule

// File: tb/tb_irq_arbiter.sv
// Bench for irq_arbiter: directed stimulus, a cycle-level reference model and literal spot checks.
module tb_irq_arbiter;
  localparam int NUM = 32;
`ifdef IRQ_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [31:0] irq_src = '0;
  logic [31:0] irq;
  logic        eoi = 1'b0;
  logic        reg_we = 1'b0;
  logic        reg_re = 1'b0;
  logic [3:0]  reg_addr = '0;
  logic [31:0] reg_wdata = '0;
  logic [31:0] reg_rdata;

  int checks = 0;
  int errors = 0;

  irq_arbiter #(.NUM_IRQ(NUM)) dut (
    .clk(clk), .resetn(resetn), .irq_src(irq_src), .irq(irq), .eoi(eoi),
    .reg_we(reg_we), .reg_re(reg_re), .reg_addr(reg_addr),
    .reg_wdata(reg_wdata), .reg_rdata(reg_rdata)
  );

  always #5 clk = ~clk;

  // Reference model: pending/enable words, granted id (-1 = none), remaining forced-low cycles.
  bit [31:0] m_pend, m_en, m_src_q, m_rdata;
  int        m_gid, m_gap, m_ptr;
  bit [31:0] t_cand, t_clr, t_set, t_w1c;
  int        t_gid, t_gap, t_ptr;

  function automatic int pick(input bit [31:0] c, input int ptr);
    for (int i = 0; i < NUM; i++) begin
      int j;
      j = (ptr + i) % NUM;
      if (c[j]) return j;
    end
    return -1;
  endfunction

  function automatic bit [31:0] exp_irq(input int gid);
    return (gid >= 0) ? (32'd1 << gid) : 32'd0;
  endfunction

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_pend <= '0; m_en <= '0; m_src_q <= '0; m_rdata <= '0;
      m_gid <= -1; m_gap <= 0; m_ptr <= 0;
    end else begin
      t_cand = m_pend & m_en;
      t_clr = '0; t_gid = m_gid; t_gap = m_gap; t_ptr = m_ptr;
      if (m_gid >= 0) begin
        if (eoi) begin t_gid = -1; t_gap = 1; end
      end else if (m_gap > 0) begin
        t_gap = m_gap - 1;
      end else if (t_cand != 0) begin
        t_gid = pick(t_cand, RR ? m_ptr : 0);
        t_clr = 32'd1 << t_gid;
        t_ptr = (t_gid + 1) % NUM;
      end
      t_w1c = (reg_we && reg_addr[3:2] == 2'd0) ? reg_wdata : '0;
      t_set = (irq_src & ~m_src_q) | ((reg_we && reg_addr[3:2] == 2'd3) ? reg_wdata : '0);
      m_pend  <= (m_pend & ~t_w1c & ~t_clr) | t_set;
      m_src_q <= irq_src;
      if (reg_we && reg_addr[3:2] == 2'd1) m_en <= reg_wdata;
      m_gid <= t_gid;
      m_gap <= t_gap;
      m_ptr <= t_ptr;
      if (reg_re) begin
        case (reg_addr[3:2])
          2'd0: m_rdata <= m_pend;
          2'd1: m_rdata <= m_en;
          2'd2: m_rdata <= (m_gid >= 0) ? (32'h8000_0000 | 32'(m_gid)) : 32'd0;
          default: m_rdata <= '0;
        endcase
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (resetn) begin
      checks++;
      if (irq !== exp_irq(m_gid)) begin
        errors++;
        $display("FAIL model_irq t=%0t got %h want %h", $time, irq, exp_irq(m_gid));
      end
      checks++;
      if (reg_rdata !== m_rdata) begin
        errors++;
        $display("FAIL model_rdata t=%0t got %h want %h", $time, reg_rdata, m_rdata);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    reg_we = 1'b1; reg_addr = a; reg_wdata = d;
    tick();
    reg_we = 1'b0; reg_wdata = '0;
  endtask

  task automatic rd(input logic [3:0] a, output logic [31:0] d);
    reg_re = 1'b1; reg_addr = a;
    tick();
    reg_re = 1'b0;
    d = reg_rdata;
  endtask

  task automatic pulse_src(input logic [31:0] v);
    irq_src = v;
    tick();
    irq_src = '0;
  endtask

  task automatic pulse_eoi();
    eoi = 1'b1;
    tick();
    eoi = 1'b0;
  endtask

  task automatic wait_irq(input string name);
    int n;
    n = 0;
    while (irq == 0 && n < 20) begin tick(); n++; end
    if (irq == 0) begin
      checks++; errors++;
      $display("FAIL %s timeout waiting for grant got %h want nonzero", name, irq);
    end
  endtask

  logic [31:0] rv;

  initial begin
    tick(3);
    check("reset_irq", irq, 32'h0);
    check("reset_rdata", reg_rdata, 32'h0);
    resetn = 1'b1;
    tick(2);

    // Basic grant: edge sampled, pending next, grant one cycle later.
    wr(4'h4, 32'h1);
    irq_src = 32'h1;
    tick();
    irq_src = '0;
    check("t1_no_grant_yet", irq, 32'h0);
    tick();
    check("t1_grant", irq, 32'h1);
    rd(4'h8, rv);
    check("t1_active", rv, 32'h8000_0000);
    pulse_eoi();
    check("t1_released", irq, 32'h0);
    rd(4'h0, rv);
    check("t1_pending_clear", rv, 32'h0);
    tick(2);

    // Simultaneous sources 3 and 5, gap between grants.
    wr(4'h4, 32'hFFFF_FFFF);
    pulse_src(32'h28);
    wait_irq("t2_first");
    check("t2_first", irq, 32'h8);
    pulse_eoi();
    check("t2_gap0", irq, 32'h0);
    tick();
    check("t2_gap1", irq, 32'h0);
    tick();
    check("t2_second", irq, 32'h20);
    pulse_eoi();
    tick(3);

    // Software trigger on a disabled source, then enable it; stray eoi ignored.
    wr(4'h4, 32'h0);
    wr(4'hC, 32'h10);
    pulse_eoi();
    rd(4'h0, rv);
    check("t3_pending", rv, 32'h10);
    check("t3_no_irq", irq, 32'h0);
    rd(4'hC, rv);
    check("t3_swtrig_reads0", rv, 32'h0);
    wr(4'h4, 32'h10);
    check("t3_enable_lat1", irq, 32'h0);
    tick();
    check("t3_enable_grant", irq, 32'h10);
    pulse_eoi();
    tick(3);

    // Edge on source 2 in the same cycle as a W1C of bit 2: the set wins.
    pulse_src(32'h4);
    tick();
    irq_src = 32'h0;
    tick();
    irq_src = 32'h4;
    reg_we = 1'b1; reg_addr = 4'h0; reg_wdata = 32'h4;
    tick();
    irq_src = '0; reg_we = 1'b0; reg_wdata = '0;
    rd(4'h0, rv);
    check("t4_set_wins", rv, 32'h4);
    wr(4'h0, 32'h4);
    rd(4'h0, rv);
    check("t4_w1c", rv, 32'h0);

    // Re-edge during ACTIVE and enable toggling do not disturb the grant.
    wr(4'h4, 32'h80);
    pulse_src(32'h80);
    wait_irq("t5_grant");
    check("t5_grant", irq, 32'h80);
    tick();
    pulse_src(32'h80);
    wr(4'h4, 32'h0);
    check("t5_hold_disabled", irq, 32'h80);
    wr(4'h4, 32'h80);
    rd(4'h0, rv);
    check("t5_repending", rv, 32'h80);
    check("t5_hold", irq, 32'h80);
    pulse_eoi();
    check("t5_released", irq, 32'h0);
    tick();
    check("t5_gap", irq, 32'h0);
    tick();
    check("t5_regrant", irq, 32'h80);

    // Asynchronous reset in the middle of a grant.
    #2 resetn = 1'b0;
    #1 check("t6_async_irq", irq, 32'h0);
    tick(2);
    resetn = 1'b1;
    tick();
    rd(4'h0, rv);
    check("t6_pending", rv, 32'h0);
    rd(4'h4, rv);
    check("t6_enable", rv, 32'h0);
    tick(4);
    check("t6_no_grant", irq, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout got running want finished");
    $fatal(1);
  end

endmodule

// File: doc/irq_arbiter.md
# irq_arbiter

Interrupt arbiter between the peripheral interrupt sources and the core's 32-bit `irq` / `eoi` handshake. Edge-detects up to `NUM_IRQ` level sources into a pending register and masks them with a software enable register. Presents exactly one granted source at a time to the core as a one-hot vector, then holds it until the core pulses `eoi`. Sits in `peripherals` between the source blocks (ethernet, uart, buttons) and the `irq`/`eoi` pair that runs to `core_region`; software configures it through a simple register port driven by the AXI-Lite slave decoder.

## Interface
- `NUM_IRQ`, 32, number of sources (1..32); upper `irq` bits tie to 0.
- `clk` input 1: sole clock; all logic is synchronous to its rising edge.
- `resetn` input 1: asynchronous, active-low reset.
- `irq_src` input NUM_IRQ: level interrupt requests, synchronous to `clk`.
- `irq` output 32: one-hot grant to the core; all zero when nothing is granted.
- `eoi` input 1: one-cycle end-of-interrupt pulse from the core.
- `reg_we` input 1: register write strobe.
- `reg_re` input 1: register read strobe.
- `reg_addr` input 4: byte address; bits [1:0] are ignored.
- `reg_wdata` input 32: write data.
- `reg_rdata` output 32: read data, registered.

## Operation
- Registers:
  - 0x0 PENDING: read; write-1-to-clear.
  - 0x4 ENABLE: read/write; reset value 0.
  - 0x8 ACTIVE: read-only; bit31 = grant valid, [4:0] = granted id.
  - 0xC SWTRIG: write-only; write-1-to-set PENDING; reads as 0.
- Edge detect: `irq_src_q` is a registered copy of `irq_src`. A bit with `irq_src & ~irq_src_q` sets the matching PENDING bit.
- Write priority on PENDING: set (edge or SWTRIG) wins over a same-cycle W1C.
- State machine, states IDLE, ACTIVE, GAP:
  - IDLE: if `PENDING & ENABLE` is nonzero, select the winner, register `irq` as one-hot(winner), clear that PENDING bit, and go to ACTIVE.
  - ACTIVE: hold `irq`. When `eoi` is high, drive `irq` to 0 and go to GAP.
  - GAP: one cycle with `irq` = 0, then go to IDLE. This guarantees a low cycle between consecutive grants.
- Winner selection: lowest index wins (fixed priority), unless round-robin is compiled in (see Configuration).
- Boundary rules:
  - `eoi` outside ACTIVE is ignored.
  - A new edge on the granted source during ACTIVE sets PENDING again. That event is serviced after the current `eoi`.
  - Clearing an ENABLE bit during ACTIVE does not revoke the grant; the arbiter still waits for `eoi`.
  - An ENABLE=0 source still collects PENDING; it is granted once enabled.
  - Bits at or above `NUM_IRQ` read 0 in PENDING/ENABLE and ignore writes.
- Reset (at any time, including mid-grant): PENDING, ENABLE, `irq_src_q`, `irq`, `reg_rdata` and the RR pointer all go to 0; the state goes to IDLE.

## Timing
- Source rising edge sampled at edge k: PENDING is visible after k; `irq` is valid after k+1. Latency is 2 cycles.
- `eoi` sampled at edge m: `irq`=0 after m; state is IDLE after m+1; the earliest next grant is valid after m+2.
- Register write takes effect after the strobe edge. A write to ENABLE at edge k can produce a grant after k+1.
- Read: `reg_rdata` is valid the cycle after `reg_re`, and holds its value until the next read.
- PENDING read and grant in the same cycle: the read returns the value before the clear.

## Configuration
- `IRQ_ROUND_ROBIN_EN`:
  - Defined: a 5-bit pointer is set to (granted id + 1) mod `NUM_IRQ` on each grant. Winner = first `PENDING & ENABLE` bit searching upward from the pointer, with wrap-around.
  - Undefined: pointer logic is removed; fixed priority, lowest index wins.

## Test plan
- Reset, then set ENABLE=0x1, then pulse `irq_src[0]` -> `irq`=0x00000001 two cycles after the sampled edge; ACTIVE reads 0x80000000. After `eoi`, `irq`=0 and PENDING=0.
- ENABLE=0xFFFFFFFF; raise `irq_src[5]` and `irq_src[3]` together -> fixed build grants 0x8, then 0x20 after `eoi` with one zero cycle between. With `IRQ_ROUND_ROBIN_EN`, sources 3 and 5 held re-pending alternate 3, 5, 3.
- ENABLE=0; SWTRIG write 0x10 -> PENDING=0x10 and `irq`=0. Write ENABLE=0x10 -> `irq`=0x10 after 2 cycles.
- Source-2 edge in the same cycle as a PENDING W1C of 0x4 -> PENDING bit 2 remains 1.
- Grant source 7; re-edge `irq_src[7]` during ACTIVE; clear ENABLE[7]; set it again -> `irq` holds 0x80 until `eoi`, then 0x80 is granted again after GAP.
- Assert `resetn`=0 during ACTIVE -> `irq`=0 immediately (async); PENDING=ENABLE=0; no grant after release until new stimulus.
